pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage CPU pipeline (IF, ID, EX, MEM, WB). Takes hazard information from the ID decoder (source-register use, branch, mul/div start or wait) and the downstream stages, and produces per-stage stall and flush strobes. It owns the multi-cycle mul/div busy counter and the exception flush sequence, so the stage modules carry no hazard logic of their own.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the five-stage pipeline
// (IF, ID, EX, MEM, WB).
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt, id_fwdEN   ID source registers and which of them are read
//   id_branch                ID instruction resolves a branch / jr in ID
//   id_mdStart, id_mdWait    mul/div start (01 mul, 10 div) and HI/LO wait
//   ex_wbReg, ex_load        EX destination register and load flag
//   mem_wbReg, mem_load      MEM destination register and load flag
//   imem_stall, dmem_stall   cache not-ready indications
//   exc_req                  MEM exception / eret request
//   stall_*, flush_*         per-stage hold / bubble strobes (combinational)
//   pc_redirect              IF loads the exception / eret target
//   md_busy, md_done         mul/div occupancy and last-cycle pulse
//   perf_stall, perf_flush   performance counters
//
// Optional feature: define PIPE_HAZARD_PERF_EN to build the performance
// counters; otherwise both perf ports are tied to zero.

module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_fwdEN,
  input  logic        id_branch,
  input  logic [1:0]  id_mdStart,
  input  logic        id_mdWait,
  input  logic [4:0]  ex_wbReg,
  input  logic [4:0]  mem_wbReg,
  input  logic        ex_load,
  input  logic        mem_load,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  input  logic        exc_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic        pc_redirect,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
);

  localparam logic [1:0] StRun      = 2'd0;
  localparam logic [1:0] StExcHold  = 2'd1;
  localparam logic [1:0] StExcFlush = 2'd2;

  localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] md_cnt_q, md_cnt_d;

  logic ex_match, mem_match;
  logic load_use, branch_haz, md_wait;
  logic md_start_op, md_start, md_dec;

  // A source matches only if it is actually read; r0 never creates a hazard.
  assign ex_match  = (ex_wbReg != 5'd0) &&
                     ((id_fwdEN[1] && (id_rs == ex_wbReg)) ||
                      (id_fwdEN[0] && (id_rt == ex_wbReg)));
  assign mem_match = (mem_wbReg != 5'd0) &&
                     ((id_fwdEN[1] && (id_rs == mem_wbReg)) ||
                      (id_fwdEN[0] && (id_rt == mem_wbReg)));

  assign load_use   = ex_load & ex_match;
  assign branch_haz = id_branch & (ex_match | (mem_load & mem_match));
  // Only the registered counter is used here: the in-flight start term of
  // md_busy depends on stall_id and would close a combinational loop.
  assign md_wait    = id_mdWait & (md_cnt_q != 6'd0);

  // Stall/flush decode and exception sequencing.
  always_comb begin
    state_d     = state_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    pc_redirect = 1'b0;
    case (state_q)
      StRun: begin
        if (dmem_stall) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
        end else if (imem_stall) begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end else if (md_wait || load_use || branch_haz) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        if (exc_req) begin
          state_d = dmem_stall ? StExcHold : StExcFlush;
        end
      end
      StExcHold: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        if (!dmem_stall) begin
          state_d = StExcFlush;
        end
      end
      StExcFlush: begin
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
        flush_mem   = 1'b1;
        pc_redirect = 1'b1;
        state_d     = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Mul/div busy counter; exceptions do not cancel an operation in progress.
  always_comb begin
    md_start_op = (id_mdStart == 2'b01) || (id_mdStart == 2'b10);
    md_start    = md_start_op && !stall_id && (state_q == StRun);
    md_dec      = (md_cnt_q != 6'd0) && !stall_ex;
    md_cnt_d    = md_cnt_q;
    if (md_start) begin
      md_cnt_d = (id_mdStart == 2'b01) ? MulLoad : DivLoad;
    end else if (md_dec) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end
    md_busy = (md_cnt_q != 6'd0) || md_start;
    md_done = (md_cnt_q == 6'd1) && md_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    // Stall count saturates; flush count wraps.
    if (stall_id && (perf_stall_q != 32'hffff_ffff)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (state_q == StExcFlush) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MulCycles = 4;
  localparam int unsigned DivCycles = 32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_wbReg, mem_wbReg;
  logic [1:0]  id_fwdEN, id_mdStart;
  logic        id_branch, id_mdWait, ex_load, mem_load;
  logic        imem_stall, dmem_stall, exc_req;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem, pc_redirect, md_busy, md_done;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;

  pipe_hazard_ctrl #(
    .MUL_CYCLES(MulCycles),
    .DIV_CYCLES(DivCycles)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_fwdEN   (id_fwdEN),
    .id_branch  (id_branch),
    .id_mdStart (id_mdStart),
    .id_mdWait  (id_mdWait),
    .ex_wbReg   (ex_wbReg),
    .mem_wbReg  (mem_wbReg),
    .ex_load    (ex_load),
    .mem_load   (mem_load),
    .imem_stall (imem_stall),
    .dmem_stall (dmem_stall),
    .exc_req    (exc_req),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .stall_ex   (stall_ex),
    .stall_mem  (stall_mem),
    .flush_id   (flush_id),
    .flush_ex   (flush_ex),
    .flush_mem  (flush_mem),
    .pc_redirect(pc_redirect),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run;
  int unsigned tests_failed;

  // Model state: exception phase (0 running, 1 waiting on D-cache, 2 flushing)
  // and number of busy cycles left on the mul/div unit.
  int          m_phase;
  int          m_left;
  logic [31:0] m_perf_stall;
  logic [15:0] m_perf_flush;
  logic [9:0]  last_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [4:0] r);
    return (r != 5'd0) && ((id_fwdEN[1] && id_rs == r) || (id_fwdEN[0] && id_rt == r));
  endfunction

  function automatic logic [9:0] dut_outs();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem,
            pc_redirect, md_busy, md_done};
  endfunction

  // Expected outputs {stall if/id/ex/mem, flush id/ex/mem, redirect, busy, done}.
  task automatic model_eval(output logic [9:0] e, output bit start_ok);
    bit s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, redir, busy, done;
    bit front;
    {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, redir} = '0;
    front = (id_mdWait && m_left > 0) ||
            (ex_load && reads_reg(ex_wbReg)) ||
            (id_branch && (reads_reg(ex_wbReg) || (mem_load && reads_reg(mem_wbReg))));
    if (m_phase == 1) begin
      {s_if, s_id, s_ex, s_mem} = 4'b1111;
    end else if (m_phase == 2) begin
      {f_id, f_ex, f_mem, redir} = 4'b1111;
    end else if (dmem_stall) begin
      {s_if, s_id, s_ex, s_mem} = 4'b1111;
    end else if (imem_stall) begin
      s_if = 1'b1;
      f_id = 1'b1;
    end else if (front) begin
      s_if = 1'b1;
      s_id = 1'b1;
      f_ex = 1'b1;
    end
    start_ok = (id_mdStart == 2'd1 || id_mdStart == 2'd2) && !s_id && m_phase == 0;
    busy = (m_left > 0) || start_ok;
    done = (m_left == 1) && !s_ex;
    e = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, redir, busy, done};
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_left       = 0;
    m_perf_stall = '0;
    m_perf_flush = '0;
  endtask

  task automatic check_perf();
`ifdef PIPE_HAZARD_PERF_EN
    check_eq("perf_stall", perf_stall, m_perf_stall);
    check_eq("perf_flush", {16'd0, perf_flush}, {16'd0, m_perf_flush});
`else
    check_eq("perf_stall", perf_stall, 32'd0);
    check_eq("perf_flush", {16'd0, perf_flush}, 32'd0);
`endif
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model.
  task automatic tick(input string tag);
    logic [9:0] e;
    bit         st;
    @(negedge clk);
    model_eval(e, st);
    last_out = dut_outs();
    check_eq(tag, {22'd0, last_out}, {22'd0, e});
    check_perf();
    if (st) begin
      m_left = ((id_mdStart == 2'd1) ? MulCycles : DivCycles) - 1;
    end else if (m_left > 0 && !e[7]) begin
      m_left--;
    end
    if (e[8] && m_perf_stall != 32'hffff_ffff) m_perf_stall = m_perf_stall + 32'd1;
    if (m_phase == 2) m_perf_flush = m_perf_flush + 16'd1;
    case (m_phase)
      0: if (exc_req) m_phase = dmem_stall ? 1 : 2;
      1: if (!dmem_stall) m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_fwdEN = '0; id_branch = 1'b0;
    id_mdStart = '0; id_mdWait = 1'b0;
    ex_wbReg = '0; mem_wbReg = '0; ex_load = 1'b0; mem_load = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0; exc_req = 1'b0;
  endtask

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    set_idle();
    rst_n = 1'b0;
    #2;
    check_eq({tag, "_outs"}, {22'd0, dut_outs()}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, md_busy}, 32'd0);
    check_eq({tag, "_perf"}, perf_stall, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls, busy_cnt, done_at;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    last_out     = '0;
    set_idle();
    model_reset();
    #1;
    do_reset("reset");
    tick("idle");

    // Load-use on r5 through rt, then the bubble has passed.
    ex_load = 1'b1; ex_wbReg = 5'd5; id_rt = 5'd5; id_fwdEN = 2'b01;
    tick("lu_hit");
    check_eq("lu_stall", {22'd0, last_out}, 32'b1100_0100_00);
    set_idle(); id_rt = 5'd5; id_fwdEN = 2'b01;
    tick("lu_after");
    check_eq("lu_clear", {31'd0, last_out[8]}, 32'd0);
    // Same with destination r0: no hazard.
    ex_load = 1'b1; ex_wbReg = 5'd0; id_rt = 5'd0; id_fwdEN = 2'b01;
    tick("lu_r0");
    check_eq("lu_r0_stall", {31'd0, last_out[8]}, 32'd0);

    // Branch on r3 after a load to r3: EX match, then MEM load match.
    set_idle(); id_branch = 1'b1; id_rs = 5'd3; id_fwdEN = 2'b10;
    ex_load = 1'b1; ex_wbReg = 5'd3;
    tick("br_ex");
    check_eq("br_ex_stall", {31'd0, last_out[8]}, 32'd1);
    ex_load = 1'b0; ex_wbReg = 5'd0; mem_load = 1'b1; mem_wbReg = 5'd3;
    tick("br_mem");
    check_eq("br_mem_stall", {31'd0, last_out[8]}, 32'd1);
    mem_load = 1'b0; mem_wbReg = 5'd0;
    tick("br_go");
    check_eq("br_go_stall", {31'd0, last_out[8]}, 32'd0);

    // Divide followed immediately by mfhi.
    set_idle(); id_mdStart = 2'b10; id_mdWait = 1'b1;
    tick("div_issue");
    busy_cnt = last_out[1] ? 1 : 0;
    stalls   = 0;
    done_at  = -1;
    id_mdStart = 2'b00;
    for (int n = 1; n < 100; n++) begin
      tick("mfhi");
      if (last_out[1]) busy_cnt++;
      if (last_out[0]) done_at = n;
      if (!last_out[8]) break;
      stalls++;
    end
    check_eq("mfhi_stalls", stalls, 31);
    check_eq("div_busy_cycles", busy_cnt, 32);
    check_eq("div_done_cycle", done_at, 31);

    // Exception while the D-cache stalls, then the single flush cycle.
    set_idle(); exc_req = 1'b1; dmem_stall = 1'b1;
    tick("exc_req");
    exc_req = 1'b0;
    tick("exc_hold1");
    tick("exc_hold2");
    dmem_stall = 1'b0;
    tick("exc_hold_rel");
    tick("exc_flush");
    check_eq("exc_redirect", {31'd0, last_out[2]}, 32'd1);
    tick("exc_run");

    // Reset in the middle of EXC_HOLD: no redirect afterwards.
    exc_req = 1'b1; dmem_stall = 1'b1;
    tick("hold_enter");
    exc_req = 1'b0;
    tick("hold_mid");
    do_reset("rst_hold");
    tick("rst_hold_after");

    // Reset in the middle of a divide with ten cycles left.
    id_mdStart = 2'b10; id_mdWait = 1'b1;
    tick("div2_issue");
    set_idle();
    repeat (21) tick("div2_run");
    do_reset("rst_div");
    tick("rst_div_after");

    // Random traffic with a small register pool so matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      int r;
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_wbReg   = 5'($urandom_range(0, 3));
      mem_wbReg  = 5'($urandom_range(0, 3));
      id_fwdEN   = 2'($urandom_range(0, 3));
      id_branch  = ($urandom_range(0, 3) == 0);
      ex_load    = ($urandom_range(0, 1) == 0);
      mem_load   = ($urandom_range(0, 1) == 0);
      r          = $urandom_range(0, 15);
      id_mdStart = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      id_mdWait  = (id_mdStart != 2'b00) || ($urandom_range(0, 3) == 0);
      imem_stall = ($urandom_range(0, 5) == 0);
      dmem_stall = ($urandom_range(0, 5) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
